// File: rtl/exc_commit.sv
// exc_commit -- exception commit unit at the MEM/WB boundary.
//
// Prioritises the MEM instruction's exception flags against pending
// interrupts and presents the winner to the CP0 block (type, PC, delay-slot
// flag, bad address).  It also produces the pipeline flush and the redirect
// PC.  After every commit, a short blackout keeps a second commit from
// following too soon.  An interrupt request raised while MEM holds a bubble
// or is stalled is latched, so it commits on the first usable cycle.
//
// Parameters:
//   EXC_VECTOR  redirect target for every exception except ERET
//   BLACKOUT    cycles after a flush with no new commit (1..7)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid_i, stall_i     MEM holds a real instruction / MEM is stalled
//   mem_pc_i, mem_in_ds_i    MEM instruction PC and delay-slot flag
//   mem_data_addr_i          load/store effective address
//   exc_flags_i              {adel_fetch, ri, ov, syscall, brk, eret,
//                             adel_load, ades}
//   cp0_status/cause/epc_i   current CP0 register values
//   wb_cp0_we/waddr/wdata_i  MTC0 write in WB, forwarded into this cycle
//   excepttype_o             exception code, 0 = none
//   exc_pc_o, exc_in_ds_o    pass-through of the MEM PC and delay-slot flag
//   bad_addr_o               faulting virtual address, 0 if not applicable
//   flush_o, new_pc_o        flush IF..MEM and the redirect target
// Optional build macro EXC_COMMIT_STAT_EN adds exc_count_o (commit counter)
// and last_code_o (code of the most recent commit).
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned BLACKOUT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_data_addr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
`ifdef EXC_COMMIT_STAT_EN
  output logic [31:0] exc_count_o,
  output logic [4:0]  last_code_o,
`endif
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_ds_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [2:0] BLK_LOAD = 3'(BLACKOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BLOCK = 1'b1
  } state_t;

  state_t      state_r;
  logic [2:0]  blk_cnt_r;
  logic        int_pend_r;

  logic [31:0] eff_status_s;
  logic [31:0] eff_epc_s;
  logic [7:0]  eff_ip_s;
  logic        int_req_s;
  logic        commit_ok_s;
  logic [4:0]  code_s;
  logic [31:0] bad_addr_s;
  logic        unused_s;

  // CP0 forwarding from an MTC0 in WB; cause forwards only the software
  // interrupt bits 9:8, hardware lines 15:10 always come from CP0.
  always_comb begin
    eff_status_s = cp0_status_i;
    eff_epc_s    = cp0_epc_i;
    eff_ip_s     = cp0_cause_i[15:8];
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12)) begin
      eff_status_s = wb_cp0_wdata_i;
    end else begin
      eff_status_s = cp0_status_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14)) begin
      eff_epc_s = wb_cp0_wdata_i;
    end else begin
      eff_epc_s = cp0_epc_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13)) begin
      eff_ip_s = {cp0_cause_i[15:10], wb_cp0_wdata_i[9:8]};
    end else begin
      eff_ip_s = cp0_cause_i[15:8];
    end
  end

  assign int_req_s = eff_status_s[0] & ~eff_status_s[1] &
                     (|(eff_ip_s & eff_status_s[15:8]));

  // Reset also gates commits so every output reads "no exception" under rst.
  assign commit_ok_s = ~rst & (state_r == ST_IDLE) & mem_valid_i & ~stall_i;

  // Priority encoder: interrupt first, then the flags MSB-first.
  always_comb begin
    code_s     = 5'h00;
    bad_addr_s = 32'h0000_0000;
    if (!commit_ok_s) begin
      code_s     = 5'h00;
      bad_addr_s = 32'h0000_0000;
    end else if (int_pend_r || int_req_s) begin
      code_s = 5'h01;
    end else if (exc_flags_i[7]) begin
      code_s     = 5'h04;
      bad_addr_s = mem_pc_i;
    end else if (exc_flags_i[6]) begin
      code_s = 5'h0a;
    end else if (exc_flags_i[5]) begin
      code_s = 5'h0c;
    end else if (exc_flags_i[4]) begin
      code_s = 5'h08;
    end else if (exc_flags_i[3]) begin
      code_s = 5'h09;
    end else if (exc_flags_i[2]) begin
      code_s = 5'h0e;
    end else if (exc_flags_i[1]) begin
      code_s     = 5'h04;
      bad_addr_s = mem_data_addr_i;
    end else if (exc_flags_i[0]) begin
      code_s     = 5'h05;
      bad_addr_s = mem_data_addr_i;
    end else begin
      code_s     = 5'h00;
      bad_addr_s = 32'h0000_0000;
    end
  end

  assign excepttype_o = {27'd0, code_s};
  assign bad_addr_o   = bad_addr_s;
  assign flush_o      = (code_s != 5'h00);
  assign new_pc_o     = !flush_o ? 32'h0000_0000 :
                        (code_s == 5'h0e) ? eff_epc_s : EXC_VECTOR;
  assign exc_pc_o     = mem_pc_i;
  assign exc_in_ds_o  = mem_in_ds_i;

  // Commit FSM: blackout counter and interrupt latch.  The latch follows the
  // live request and is dropped by the interrupt's own commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      blk_cnt_r  <= 3'd0;
      int_pend_r <= 1'b0;
    end else begin
      int_pend_r <= int_req_s & ~(flush_o && (code_s == 5'h01));
      case (state_r)
        ST_IDLE: begin
          if (flush_o) begin
            state_r   <= ST_BLOCK;
            blk_cnt_r <= BLK_LOAD;
          end else begin
            state_r   <= ST_IDLE;
            blk_cnt_r <= 3'd0;
          end
        end
        ST_BLOCK: begin
          if (blk_cnt_r == 3'd0) begin
            state_r <= ST_IDLE;
          end else begin
            blk_cnt_r <= blk_cnt_r - 3'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          blk_cnt_r <= 3'd0;
        end
      endcase
    end
  end

`ifdef EXC_COMMIT_STAT_EN
  logic [31:0] exc_count_r;
  logic [4:0]  last_code_r;

  // Commit statistics: wrapping commit counter and last committed code.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_r <= 32'd0;
      last_code_r <= 5'd0;
    end else if (flush_o) begin
      exc_count_r <= exc_count_r + 32'd1;
      last_code_r <= code_s;
    end else begin
      exc_count_r <= exc_count_r;
      last_code_r <= last_code_r;
    end
  end

  assign exc_count_o = exc_count_r;
  assign last_code_o = last_code_r;
`endif

  // CP0 fields this unit never looks at.
  assign unused_s = ^{cp0_cause_i[31:16], cp0_cause_i[7:0],
                      eff_status_s[31:16], eff_status_s[7:2]};

endmodule
